cnt_obi_arbiter: RTL and testbench

- Two-to-one OBI arbiter that shares the counter's single OBI slave port (counter value read/write) between two host requesters, e.g. the CPU and a DMA channel.
- Sits between the host-side OBI buses and the counter's OBI port.
- Arbitrates round-robin and holds the winner stable while the counter stalls.
- Tracks the originator of each outstanding transaction in an ID FIFO so each rvalid/rdata returns to the requester that issued it.

---
 rtl/cnt_obi_arbiter.sv | 147 ++++++++++++++
 tb/tb_cnt_obi_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cnt_obi_arbiter.sv
// Two-to-one OBI arbiter in front of the counter's OBI slave port, with an ID FIFO for response routing.
// Build option: define CNT_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
//
// state  | meaning
// IDLE   | no stalled request; winner chosen combinationally
// LOCKED | forwarded request was not granted last cycle; winner held in locked_id
module cnt_obi_arbiter #(
    parameter int MAX_OUT = 2,
    localparam int CW = $clog2(MAX_OUT + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          h0_req_i,
    input  logic          h0_we_i,
    input  logic [3:0]    h0_be_i,
    input  logic [31:0]   h0_addr_i,
    input  logic [31:0]   h0_wdata_i,
    output logic          h0_gnt_o,
    output logic          h0_rvalid_o,
    output logic [31:0]   h0_rdata_o,
    input  logic          h1_req_i,
    input  logic          h1_we_i,
    input  logic [3:0]    h1_be_i,
    input  logic [31:0]   h1_addr_i,
    input  logic [31:0]   h1_wdata_i,
    output logic          h1_gnt_o,
    output logic          h1_rvalid_o,
    output logic [31:0]   h1_rdata_o,
    output logic          m_req_o,
    output logic          m_we_o,
    output logic [3:0]    m_be_o,
    output logic [31:0]   m_addr_o,
    output logic [31:0]   m_wdata_o,
    input  logic          m_gnt_i,
    input  logic          m_rvalid_i,
    input  logic [31:0]   m_rdata_i,
    output logic [CW-1:0] outstanding_o,
    output logic          err_o
);
    localparam int PW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam logic [PW-1:0] LAST = PW'(MAX_OUT - 1);

    typedef enum logic {IDLE, LOCKED} state_t;

    state_t               state, state_nxt;
    logic                 locked_id, locked_id_nxt;
    logic                 winner, win_req, fwd;
    logic                 push, pop, full, empty, head;
    logic [MAX_OUT-1:0]   fifo_q;
    logic [PW-1:0]        wr_ptr, rd_ptr;
    logic [CW-1:0]        count;
    logic                 err;
`ifndef CNT_ARB_FIXED_PRIO_EN
    logic                 rr_ptr;
`endif

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign full  = (count == CW'(MAX_OUT));
    assign empty = (count == '0);

    always_comb begin
        winner = 1'b0;
        if (state == LOCKED) begin
            winner = locked_id;
        end else if (h0_req_i && h1_req_i) begin
`ifdef CNT_ARB_FIXED_PRIO_EN
            winner = 1'b0;
`else
            winner = rr_ptr;
`endif
        end else begin
            winner = h1_req_i;
        end
    end

    assign win_req = winner ? h1_req_i : h0_req_i;
    // Combinational outputs are gated so nothing leaks out while reset is held.
    assign fwd     = win_req & ~rst_i;

    assign m_req_o   = fwd & ~full;
    assign m_we_o    = fwd & (winner ? h1_we_i : h0_we_i);
    assign m_be_o    = fwd ? (winner ? h1_be_i : h0_be_i) : '0;
    assign m_addr_o  = fwd ? (winner ? h1_addr_i : h0_addr_i) : '0;
    assign m_wdata_o = fwd ? (winner ? h1_wdata_i : h0_wdata_i) : '0;

    assign push     = m_req_o & m_gnt_i;
    assign h0_gnt_o = push & ~winner;
    assign h1_gnt_o = push & winner;

    assign head        = fifo_q[rd_ptr];
    assign pop         = m_rvalid_i & ~empty & ~rst_i;
    assign h0_rvalid_o = pop & ~head;
    assign h1_rvalid_o = pop & head;
    assign h0_rdata_o  = h0_rvalid_o ? m_rdata_i : '0;
    assign h1_rdata_o  = h1_rvalid_o ? m_rdata_i : '0;

    assign outstanding_o = count;
    assign err_o         = err;

    always_comb begin
        state_nxt     = IDLE;
        locked_id_nxt = locked_id;
        if (m_req_o && !m_gnt_i) begin
            state_nxt     = LOCKED;
            locked_id_nxt = winner;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state     <= IDLE;
            locked_id <= 1'b0;
            fifo_q    <= '0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            err       <= 1'b0;
`ifndef CNT_ARB_FIXED_PRIO_EN
            rr_ptr    <= 1'b0;
`endif
        end else begin
            state     <= state_nxt;
            locked_id <= locked_id_nxt;
            if (push) begin
                fifo_q[wr_ptr] <= winner;
                wr_ptr         <= ptr_inc(wr_ptr);
`ifndef CNT_ARB_FIXED_PRIO_EN
                rr_ptr         <= ~winner;
`endif
            end
            if (pop) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (m_rvalid_i && empty) begin
                err <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_cnt_obi_arbiter.sv
// Scoreboard bench for cnt_obi_arbiter: directed stimulus pushes expected grants/responses, a monitor checks them.
module tb_cnt_obi_arbiter;
    localparam int MAX_OUT = 2;
    localparam int CW = $clog2(MAX_OUT + 1);

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          h0_req = 0, h0_we = 0, h1_req = 0, h1_we = 0;
    logic [3:0]    h0_be = 0, h1_be = 0;
    logic [31:0]   h0_addr = 0, h0_wdata = 0, h1_addr = 0, h1_wdata = 0;
    logic          h0_gnt, h0_rvalid, h1_gnt, h1_rvalid;
    logic [31:0]   h0_rdata, h1_rdata;
    logic          m_req, m_we, m_gnt = 0, m_rvalid = 0;
    logic [3:0]    m_be;
    logic [31:0]   m_addr, m_wdata, m_rdata = 0;
    logic [CW-1:0] outstanding;
    logic          err;

    int tests = 0;
    int fails = 0;
    logic [1:0]  exp_gnt[$];
    logic [32:0] exp_rsp[$];

`ifdef CNT_ARB_FIXED_PRIO_EN
    localparam bit FIXED = 1'b1;
`else
    localparam bit FIXED = 1'b0;
`endif

    cnt_obi_arbiter #(.MAX_OUT(MAX_OUT)) dut (
        .clk_i(clk), .rst_i(rst),
        .h0_req_i(h0_req), .h0_we_i(h0_we), .h0_be_i(h0_be), .h0_addr_i(h0_addr), .h0_wdata_i(h0_wdata),
        .h0_gnt_o(h0_gnt), .h0_rvalid_o(h0_rvalid), .h0_rdata_o(h0_rdata),
        .h1_req_i(h1_req), .h1_we_i(h1_we), .h1_be_i(h1_be), .h1_addr_i(h1_addr), .h1_wdata_i(h1_wdata),
        .h1_gnt_o(h1_gnt), .h1_rvalid_o(h1_rvalid), .h1_rdata_o(h1_rdata),
        .m_req_o(m_req), .m_we_o(m_we), .m_be_o(m_be), .m_addr_o(m_addr), .m_wdata_o(m_wdata),
        .m_gnt_i(m_gnt), .m_rvalid_i(m_rvalid), .m_rdata_i(m_rdata),
        .outstanding_o(outstanding), .err_o(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic quiet();
        h0_req = 0; h1_req = 0; h0_we = 0; h1_we = 0;
        m_gnt = 0; m_rvalid = 0; m_rdata = 0;
    endtask

    task automatic do_reset();
        quiet();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    // Monitor: any grant or response must match the head of its queue.
    always @(negedge clk) begin
        if (!rst) begin
            if (h0_gnt || h1_gnt) begin
                if (exp_gnt.size() == 0) begin
                    chk("unexpected_gnt", {30'd0, h1_gnt, h0_gnt}, 32'd0);
                end else begin
                    logic [1:0] e;
                    e = exp_gnt.pop_front();
                    chk("gnt_route", {30'd0, h1_gnt, h0_gnt}, {30'd0, e});
                end
            end
            if (h0_rvalid || h1_rvalid) begin
                if (exp_rsp.size() == 0) begin
                    chk("unexpected_rvalid", {30'd0, h1_rvalid, h0_rvalid}, 32'd0);
                end else begin
                    logic [32:0] r;
                    r = exp_rsp.pop_front();
                    chk("rvalid_route", {30'd0, h1_rvalid, h0_rvalid}, r[32] ? 32'd2 : 32'd1);
                    chk("rdata", r[32] ? h1_rdata : h0_rdata, r[31:0]);
                    chk("rdata_other_zero", r[32] ? h0_rdata : h1_rdata, 32'd0);
                end
            end
        end
    end

    logic ids[5];

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst_m_req", {31'd0, m_req}, 0);
        chk("rst_outstanding", {{(32-CW){1'b0}}, outstanding}, 0);
        chk("rst_err", {31'd0, err}, 0);
        chk("rst_gnt", {30'd0, h1_gnt, h0_gnt}, 0);
        chk("rst_rvalid", {30'd0, h1_rvalid, h0_rvalid}, 0);
        cyc();
        rst = 1'b0;

        // Single requester read
        h0_req = 1; h0_addr = 32'h0; m_gnt = 1;
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        chk("single_m_req", {31'd0, m_req}, 1);
        chk("single_h1_gnt", {31'd0, h1_gnt}, 0);
        cyc();
        h0_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h2A;
        exp_rsp.push_back({1'b0, 32'h2A});
        @(negedge clk);
        chk("single_h1_rvalid", {31'd0, h1_rvalid}, 0);
        chk("single_h1_rdata", h1_rdata, 0);
        cyc();
        m_rvalid = 0;

        // Contention with immediate grant; rvalid one cycle after each grant
        do_reset();
        h0_addr = 32'h100; h1_addr = 32'h200;
        for (int k = 0; k < 5; k++) begin
            h0_req = (k < 4); h1_req = (k < 4); m_gnt = (k < 4);
            if (k < 4) begin
                ids[k] = FIXED ? 1'b0 : k[0];
                exp_gnt.push_back(ids[k] ? 2'b10 : 2'b01);
            end
            m_rvalid = (k > 0);
            m_rdata = 32'h100 + k;
            if (k > 0) exp_rsp.push_back({ids[k-1], m_rdata});
            @(negedge clk);
            if (k < 4) chk("cont_m_addr", m_addr, ids[k] ? 32'h200 : 32'h100);
            cyc();
        end
        quiet();
        @(negedge clk);
        chk("cont_drained", {{(32-CW){1'b0}}, outstanding}, 0);
        cyc();

        // Stall lock
        do_reset();
        h0_req = 1; h1_req = 1; h0_addr = 32'h10; h1_addr = 32'h20; m_gnt = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_m_addr", m_addr, 32'h10);
            chk("stall_m_req", {31'd0, m_req}, 1);
            chk("stall_h1_gnt", {31'd0, h1_gnt}, 0);
            cyc();
        end
        m_gnt = 1;
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        chk("stall_release_addr", m_addr, 32'h10);
        cyc();
        exp_gnt.push_back(FIXED ? 2'b01 : 2'b10);
        @(negedge clk);
        chk("stall_next_addr", m_addr, FIXED ? 32'h10 : 32'h20);
        cyc();
        h0_req = 0; h1_req = 0; m_gnt = 0;
        m_rvalid = 1; m_rdata = 32'hA0;
        exp_rsp.push_back({1'b0, 32'hA0});
        @(negedge clk);
        cyc();
        m_rdata = 32'hA1;
        exp_rsp.push_back({FIXED ? 1'b0 : 1'b1, 32'hA1});
        @(negedge clk);
        cyc();
        m_rvalid = 0;

        // Full FIFO
        do_reset();
        h0_req = 1; h0_addr = 32'h4; m_gnt = 1;
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        cyc();
        h0_req = 0; h1_req = 1; h1_addr = 32'h8;
        exp_gnt.push_back(2'b10);
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("full_outstanding", {{(32-CW){1'b0}}, outstanding}, 2);
        chk("full_m_req", {31'd0, m_req}, 0);
        chk("full_h1_gnt", {31'd0, h1_gnt}, 0);
        cyc();
        m_rvalid = 1; m_rdata = 32'h55;
        exp_rsp.push_back({1'b0, 32'h55});
        @(negedge clk);
        chk("full_no_bypass", {31'd0, m_req}, 0);
        cyc();
        m_rvalid = 0;
        exp_gnt.push_back(2'b10);
        @(negedge clk);
        chk("full_after_pop_req", {31'd0, m_req}, 1);
        chk("full_after_pop_out", {{(32-CW){1'b0}}, outstanding}, 1);
        cyc();
        h1_req = 0; m_gnt = 0; m_rvalid = 1; m_rdata = 32'h66;
        exp_rsp.push_back({1'b1, 32'h66});
        @(negedge clk);
        cyc();
        m_rdata = 32'h77;
        exp_rsp.push_back({1'b1, 32'h77});
        @(negedge clk);
        cyc();
        m_rvalid = 0;
        @(negedge clk);
        chk("full_drained", {{(32-CW){1'b0}}, outstanding}, 0);
        cyc();

        // Spurious response and async reset
        do_reset();
        m_rvalid = 1; m_rdata = 32'hDEAD;
        @(negedge clk);
        chk("spur_no_rvalid", {30'd0, h1_rvalid, h0_rvalid}, 0);
        cyc();
        m_rvalid = 0;
        @(negedge clk);
        chk("spur_err", {31'd0, err}, 1);
        chk("spur_outstanding", {{(32-CW){1'b0}}, outstanding}, 0);
        cyc();
        @(negedge clk);
        chk("spur_err_sticky", {31'd0, err}, 1);
        cyc();
        h0_req = 1; m_gnt = 1;
        exp_gnt.push_back(2'b01);
        @(negedge clk);
        cyc();
        h0_req = 0; m_gnt = 0;
        @(negedge clk);
        chk("pre_rst_outstanding", {{(32-CW){1'b0}}, outstanding}, 1);
        rst = 1'b1;
        #1;
        chk("async_rst_err", {31'd0, err}, 0);
        chk("async_rst_outstanding", {{(32-CW){1'b0}}, outstanding}, 0);
        cyc();
        rst = 1'b0;
        cyc();

        chk("gnt_queue_empty", exp_gnt.size(), 0);
        chk("rsp_queue_empty", exp_rsp.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
